// File: rtl/i2c_codec_writer.sv
// I2C write sequencer for the audio codec config path: sends {slave, reg word}
// as one I2C write, checks the three ACK slots, retries NACKed words.
module i2c_codec_writer #(
    parameter int CLK_DIV   = 20,
    parameter int MAX_RETRY = 3
) (
    input  logic        CLOCK31_5,
    input  logic        rst_n,
    input  logic        TRANSACTION_REQ,
    input  logic [23:0] DATA,
    output logic        NEXT_WORD,
    output logic        BUSY,
    output logic        ERROR,
    output logic        I2C_SCLK,
    output logic        I2C_SDAT_OE,
    input  logic        I2C_SDAT_IN
);
    localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);
    localparam logic [QW-1:0] QFIRST = (CLK_DIV > 1) ? QW'(1) : '0;

    typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_GAP} state_t;
    typedef struct packed {
        logic [7:0]  slave_addr;
        logic [15:0] reg_word;
    } word_t;

    state_t        state_q, state_d;
    logic [1:0]    q_q, q_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [23:0]   shift_q, shift_d;
    word_t         word_q, word_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          nack_q, nack_d;
    logic          fail_q, fail_d;
    logic          nw_q, nw_d;
    logic          err_q, err_d;
    logic          scl_q, scl_d;
    logic          oe_q, oe_d;
    logic [1:0]    sda_pipe;
    logic          tick;

    assign tick        = (qcnt_q == QMAX);
    assign NEXT_WORD   = nw_q;
    assign BUSY        = (state_q != S_IDLE);
    assign ERROR       = err_q;
    assign I2C_SCLK    = scl_q;
    assign I2C_SDAT_OE = oe_q;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        qcnt_d  = qcnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        word_d  = word_q;
        retry_d = retry_q;
        nack_d  = nack_q;
        fail_d  = fail_q;
        nw_d    = 1'b0;
        err_d   = err_q;
        if (state_q == S_IDLE) begin
            qcnt_d = '0;
            q_d    = 2'd0;
            if (TRANSACTION_REQ && !nw_q) begin
                word_d  = word_t'(DATA);
                shift_d = DATA;
                bit_d   = '0;
                byte_d  = '0;
                nack_d  = 1'b0;
                fail_d  = 1'b0;
                state_d = S_START;
                // The accept cycle is counted as the first cycle of START q0,
                // so a clean word completes exactly 120*CLK_DIV cycles later.
                qcnt_d  = QFIRST;
            end
        end else begin
            qcnt_d = tick ? '0 : qcnt_q + 1'b1;
            if (tick) begin
                q_d = q_q + 2'd1;
                case (state_q)
                    S_START: if (q_q == 2'd3) state_d = S_BIT;
                    S_BIT: if (q_q == 2'd3) begin
                        shift_d = {shift_q[22:0], 1'b0};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = S_ACK;
                    end
                    S_ACK: begin
                        if (q_q == 2'd2) nack_d = sda_pipe[1];
                        if (q_q == 2'd3) begin
                            if (nack_q) begin
                                fail_d  = 1'b1;
                                state_d = S_STOP;
                            end else if (byte_q == 2'd2) begin
                                state_d = S_STOP;
                            end else begin
                                byte_d  = byte_q + 2'd1;
                                state_d = S_BIT;
                            end
                        end
                    end
                    S_STOP: if (q_q == 2'd3) state_d = S_GAP;
                    S_GAP: if (q_q == 2'd3) begin
                        if (!fail_q) begin
                            nw_d    = 1'b1;
                            retry_d = '0;
                            state_d = S_IDLE;
                        end else if (retry_q < RW'(MAX_RETRY)) begin
                            retry_d = retry_q + 1'b1;
                            shift_d = word_q;
                            bit_d   = '0;
                            byte_d  = '0;
                            nack_d  = 1'b0;
                            fail_d  = 1'b0;
                            state_d = S_START;
                        end else begin
                            err_d   = 1'b1;
                            nw_d    = 1'b1;
                            retry_d = '0;
                            state_d = S_IDLE;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // Bus levels are decoded from the next state so the registered pins line
    // up with the state register and only move on quarter boundaries.
    always_comb begin
        scl_d = 1'b1;
        oe_d  = 1'b0;
        case (state_d)
            S_START: begin
                scl_d = (q_d != 2'd3);
                oe_d  = (q_d != 2'd0);
            end
            S_BIT: begin
                scl_d = (q_d == 2'd1) || (q_d == 2'd2);
                oe_d  = ~shift_d[23];
            end
            S_ACK:   scl_d = (q_d == 2'd1) || (q_d == 2'd2);
            S_STOP: begin
                scl_d = (q_d != 2'd0);
                oe_d  = (q_d < 2'd2);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK31_5 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            q_q      <= '0;
            qcnt_q   <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            shift_q  <= '0;
            word_q   <= '0;
            retry_q  <= '0;
            nack_q   <= 1'b0;
            fail_q   <= 1'b0;
            nw_q     <= 1'b0;
            err_q    <= 1'b0;
            scl_q    <= 1'b1;
            oe_q     <= 1'b0;
            sda_pipe <= 2'b11;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            qcnt_q   <= qcnt_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            shift_q  <= shift_d;
            word_q   <= word_d;
            retry_q  <= retry_d;
            nack_q   <= nack_d;
            fail_q   <= fail_d;
            nw_q     <= nw_d;
            err_q    <= err_d;
            scl_q    <= scl_d;
            oe_q     <= oe_d;
            sda_pipe <= {sda_pipe[0], I2C_SDAT_IN};
        end
    end
endmodule

// File: tb/tb_i2c_codec_writer.sv
// Bench for i2c_codec_writer: behavioural I2C slave with scripted NACKs and a
// quarter-count reference model of bytes on the bus, latency and ERROR.
module tb_i2c_codec_writer;
    localparam int CLK_DIV   = 20;
    localparam int MAX_RETRY = 3;

    logic        CLOCK31_5 = 1'b0;
    logic        rst_n;
    logic        TRANSACTION_REQ;
    logic [23:0] DATA;
    logic        NEXT_WORD, BUSY, ERROR, I2C_SCLK, I2C_SDAT_OE;
    logic        I2C_SDAT_IN;
    logic        slv_low = 1'b0;

    assign I2C_SDAT_IN = ~(I2C_SDAT_OE | slv_low);

    i2c_codec_writer #(.CLK_DIV(CLK_DIV), .MAX_RETRY(MAX_RETRY)) dut (
        .CLOCK31_5(CLOCK31_5), .rst_n(rst_n), .TRANSACTION_REQ(TRANSACTION_REQ),
        .DATA(DATA), .NEXT_WORD(NEXT_WORD), .BUSY(BUSY), .ERROR(ERROR),
        .I2C_SCLK(I2C_SCLK), .I2C_SDAT_OE(I2C_SDAT_OE), .I2C_SDAT_IN(I2C_SDAT_IN)
    );

    always #16 CLOCK31_5 = ~CLOCK31_5;

    int cyc = 0;
    always @(posedge CLOCK31_5) cyc <= cyc + 1;

    int vectors = 0, miscompares = 0;
    // plan[a]: byte index the slave NACKs on attempt a, 3 = ACK everything
    int plan [4];
    int starts = 0, stops = 0, rises = 0, nw_cnt = 0;
    logic [7:0] rx [$];
    logic [7:0] exp_q [$];
    int exp_lat, exp_starts, exp_rises;
    logic exp_err = 1'b0;
    logic [23:0] rom [11];
    int viol, addr, n;

    // Slave / bus monitor, sampling on the inactive clock edge.
    initial begin
        logic scl, sda, p_scl, p_sda;
        logic [7:0] sh;
        int bitcnt, byte_no, ai;
        p_scl = 1'b1; p_sda = 1'b1; sh = '0; bitcnt = 0; byte_no = 0; ai = 0;
        forever begin
            @(negedge CLOCK31_5);
            scl = I2C_SCLK;
            sda = I2C_SDAT_IN;
            if (rst_n !== 1'b1) begin
                slv_low = 1'b0;
                bitcnt = 0;
            end else begin
                if (scl && p_scl && p_sda && !sda) begin
                    ai = (starts < 4) ? starts : 3;
                    starts++;
                    bitcnt = 0; byte_no = 0; slv_low = 1'b0;
                end else if (scl && p_scl && !p_sda && sda) begin
                    stops++;
                end else if (scl && !p_scl) begin
                    rises++;
                    if (bitcnt < 8) sh = {sh[6:0], sda};
                    bitcnt++;
                end else if (!scl && p_scl) begin
                    if (bitcnt == 8) begin
                        rx.push_back(sh);
                        slv_low = (plan[ai] != byte_no);
                    end else if (bitcnt == 9) begin
                        slv_low = 1'b0;
                        bitcnt = 0;
                        byte_no++;
                    end
                end
                if (NEXT_WORD === 1'b1) nw_cnt++;
            end
            p_scl = scl;
            p_sda = sda;
        end
    end

    task automatic chk(input string tag, input string what, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, what, obs, exp);
        end
    endtask

    // Each attempt: START 4 + 9 quarters per byte sent + STOP 4 + GAP 4.
    // A NACKed byte is the last one of its attempt; one extra SCL rise in STOP.
    task automatic predict(input logic [23:0] d);
        exp_q.delete();
        exp_lat = 0; exp_starts = 0; exp_rises = 0;
        for (int a = 0; a <= MAX_RETRY; a++) begin
            int nb;
            nb = (plan[a] < 3) ? plan[a] + 1 : 3;
            exp_starts++;
            for (int b = 0; b < nb; b++) exp_q.push_back(d[23 - 8*b -: 8]);
            exp_rises += 9*nb + 1;
            exp_lat += (12 + 36*nb) * CLK_DIV;
            if (plan[a] == 3) return;
        end
        exp_err = 1'b1;
    endtask

    task automatic run_word(input string tag, input logic [23:0] d);
        int k, t0, lat;
        predict(d);
        starts = 0; stops = 0; rises = 0; nw_cnt = 0; rx.delete();
        DATA = d;
        TRANSACTION_REQ = 1'b1;
        k = 0;
        while (BUSY !== 1'b1 && k < 50) begin @(negedge CLOCK31_5); k++; end
        chk(tag, "accept", 32'(BUSY), 1);
        // accept happened in the cycle before BUSY is first seen
        t0 = cyc;
        TRANSACTION_REQ = 1'b0;
        DATA = 24'($urandom);
        k = 0;
        while (NEXT_WORD !== 1'b1 && k < 12000) begin @(negedge CLOCK31_5); k++; end
        lat = cyc - t0 + 1;
        chk(tag, "latency", lat, exp_lat);
        chk(tag, "busy_in_nw", 32'(BUSY), 0);
        repeat (3) @(negedge CLOCK31_5);
        chk(tag, "nw_pulses", nw_cnt, 1);
        chk(tag, "starts", starts, exp_starts);
        chk(tag, "stops", stops, exp_starts);
        chk(tag, "scl_rises", rises, exp_rises);
        chk(tag, "bytes", rx.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk(tag, $sformatf("byte%0d", i), (i < rx.size()) ? 32'(rx[i]) : 32'h1ff,
                32'(exp_q[i]));
        chk(tag, "error", 32'(ERROR), 32'(exp_err));
    endtask

    initial begin
        rom = '{24'h34_1E00, 24'h34_001A, 24'h34_021A, 24'h34_047B, 24'h34_067B,
                24'h34_08F8, 24'h34_0A06, 24'h34_0C00, 24'h34_0E01, 24'h34_1002,
                24'h34_1201};
        for (int a = 0; a < 4; a++) plan[a] = 3;
        rst_n = 1'b0; TRANSACTION_REQ = 1'b0; DATA = '0;
        repeat (3) @(negedge CLOCK31_5);
        chk("reset", "scl", 32'(I2C_SCLK), 1);
        chk("reset", "oe", 32'(I2C_SDAT_OE), 0);
        chk("reset", "busy", 32'(BUSY), 0);
        chk("reset", "next_word", 32'(NEXT_WORD), 0);
        chk("reset", "error", 32'(ERROR), 0);
        rst_n = 1'b1;

        viol = 0;
        repeat (10000) begin
            @(negedge CLOCK31_5);
            if (I2C_SCLK !== 1'b1 || I2C_SDAT_OE !== 1'b0 || BUSY !== 1'b0 || NEXT_WORD !== 1'b0)
                viol++;
        end
        chk("idle", "bad_cycles", viol, 0);
        chk("idle", "starts", starts, 0);

        run_word("clean", 24'h34_1201);

        plan[0] = 1;
        run_word("nack_b1", 24'h34_1201);

        repeat (4) begin
            for (int a = 0; a < 4; a++) begin
                int r;
                r = $urandom_range(0, 6);
                plan[a] = (r < 3) ? r : 3;
            end
            run_word("random", 24'($urandom));
        end

        for (int a = 0; a < 4; a++) plan[a] = 0;
        run_word("nack_all", 24'h34_1E00);
        for (int a = 0; a < 4; a++) plan[a] = 3;
        run_word("after_err", 24'h34_0C00);

        // Config ROM stand-in: address steps on NEXT_WORD, REQ drops after the last word.
        starts = 0; nw_cnt = 0; rx.delete(); viol = 0;
        addr = 0; DATA = rom[0]; TRANSACTION_REQ = 1'b1; n = 0;
        while (addr < 11 && n < 30000) begin
            @(negedge CLOCK31_5); n++;
            if (NEXT_WORD === 1'b1) begin
                if (BUSY !== 1'b0) viol++;
                addr++;
                if (addr < 11) DATA = rom[addr];
                else TRANSACTION_REQ = 1'b0;
            end
        end
        repeat (3) @(negedge CLOCK31_5);
        chk("rom", "nw_pulses", nw_cnt, 11);
        chk("rom", "starts", starts, 11);
        chk("rom", "bytes", rx.size(), 33);
        for (int i = 0; i < 11; i++)
            chk("rom", $sformatf("word%0d", i),
                (rx.size() >= 33) ? 32'({rx[3*i], rx[3*i+1], rx[3*i+2]}) : 32'hffff_ffff,
                32'(rom[i]));
        chk("rom", "busy_in_nw", viol, 0);
        chk("rom", "busy_end", 32'(BUSY), 0);
        chk("rom", "scl_end", 32'(I2C_SCLK), 1);
        chk("rom", "oe_end", 32'(I2C_SDAT_OE), 0);
        chk("rom", "error_sticky", 32'(ERROR), 1);

        // Reset during byte 1, bit 3, q0 (SCL low, SDA pulled low for a 0 bit).
        DATA = 24'h34_08F8; TRANSACTION_REQ = 1'b1; n = 0;
        while (BUSY !== 1'b1 && n < 50) begin @(negedge CLOCK31_5); n++; end
        repeat (1050) @(negedge CLOCK31_5);
        chk("rst_mid", "busy_before", 32'(BUSY), 1);
        chk("rst_mid", "oe_before", 32'(I2C_SDAT_OE), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid", "scl", 32'(I2C_SCLK), 1);
        chk("rst_mid", "oe", 32'(I2C_SDAT_OE), 0);
        chk("rst_mid", "busy", 32'(BUSY), 0);
        chk("rst_mid", "error", 32'(ERROR), 0);
        repeat (3) @(negedge CLOCK31_5);
        rst_n = 1'b1;
        exp_err = 1'b0;
        run_word("rst_resend", 24'h34_08F8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
